// File: rtl/cpu_oam_dma_arbiter.sv
// CPU/OAM-DMA bus arbiter: passes CPU cycles through while idle. A CPU write
// to the DMA trigger register stalls the core through RDY and copies a page
// of memory to a fixed destination port with alternating read/write cycles.
module cpu_oam_dma_arbiter #(
  parameter int unsigned          ADDR_W       = 16,
  parameter int unsigned          DATA_W       = 8,
  parameter logic [ADDR_W-1:0]    DMA_REG_ADDR = 16'h4014,
  parameter logic [ADDR_W-1:0]    DEST_ADDR    = 16'h2004,
  parameter int unsigned          XFER_LEN     = 256,
  parameter bit                   ALIGN_EN     = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              ENABLE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DATA_OUT,
  input  logic              CPU_RW_n,
  input  logic [DATA_W-1:0] BUS_DATA_IN,
  output logic              CPU_RDY,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              RW_n,
  output logic              DMA_ACTIVE,
  output logic              DMA_DONE
);

  localparam int unsigned PAGE_W   = ADDR_W - 8;
  localparam logic [7:0]  LAST_IDX = 8'(XFER_LEN - 1);

  if ((XFER_LEN < 1) || (XFER_LEN > 256)) begin : g_bad_xfer_len
    $error("cpu_oam_dma_arbiter: XFER_LEN must be in 1..256");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t              state, state_nx;
  logic                parity;
  logic [7:0]          idx;
  logic [PAGE_W-1:0]   page;
  logic [DATA_W-1:0]   latch;
  logic                done;
  logic                trigger;
  logic                last;

  assign trigger  = !CPU_RW_n && (CPU_ADDR == DMA_REG_ADDR);
  assign last     = (idx == LAST_IDX);
  assign DMA_DONE = done;

  // State, parity, transfer index, page and read-data latch; all advance on ENABLE edges
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state  <= S_IDLE;
      parity <= 1'b0;
      idx    <= '0;
      page   <= '0;
      latch  <= '0;
      done   <= 1'b0;
    end else begin
      // Done is a single-CLK pulse on the ENABLE edge that retires the last write
      done <= ENABLE && (state == S_WRITE) && last;
      if (ENABLE) begin
        state  <= state_nx;
        parity <= ~parity;
        if ((state == S_IDLE) && trigger) begin
          page <= PAGE_W'(CPU_DATA_OUT);
          idx  <= '0;
        end
        if (state == S_READ) begin
          latch <= BUS_DATA_IN;
        end
        if ((state == S_WRITE) && !last) begin
          idx <= idx + 8'd1;
        end
      end
    end
  end

  // Next-state decode and bus mux; RDY/ACTIVE are decoded from state alone
  always_comb begin
    state_nx   = state;
    ADDR       = CPU_ADDR;
    DATA_OUT   = CPU_DATA_OUT;
    RW_n       = CPU_RW_n;
    CPU_RDY    = 1'b0;
    DMA_ACTIVE = 1'b1;
    unique case (state)
      S_IDLE: begin
        CPU_RDY    = 1'b1;
        DMA_ACTIVE = 1'b0;
        if (trigger) state_nx = S_HALT;
      end
      S_HALT: begin
        RW_n = 1'b1;
        // Current parity 0 means the following cycle is odd; burn it so reads land even
        state_nx = (ALIGN_EN && !parity) ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        RW_n     = 1'b1;
        state_nx = S_READ;
      end
      S_READ: begin
        ADDR     = {page, idx};
        RW_n     = 1'b1;
        state_nx = S_WRITE;
      end
      S_WRITE: begin
        ADDR     = DEST_ADDR;
        DATA_OUT = latch;
        RW_n     = 1'b0;
        state_nx = last ? S_IDLE : S_READ;
      end
      default: begin
        CPU_RDY    = 1'b1;
        DMA_ACTIVE = 1'b0;
        state_nx   = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_oam_dma_arbiter.sv
// Directed bench for cpu_oam_dma_arbiter: pass-through vector table, then
// full-page DMA runs on both parities, a short non-aligning instance,
// ENABLE gating mid-transfer and an asynchronous reset abort.
module tb_cpu_oam_dma_arbiter;

  logic        CLK;
  logic        RESET_n;
  logic        ENABLE;

  // Main instance (256 bytes, alignment on)
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw;
  logic [7:0]  bus_in;
  logic        rdy, rw, active, done;
  logic [15:0] addr;
  logic [7:0]  dout;

  // Short instance (4 bytes, alignment off)
  logic [15:0] s_cpu_addr;
  logic [7:0]  s_cpu_dout;
  logic        s_cpu_rw;
  logic [7:0]  s_bus_in;
  logic        s_rdy, s_rw, s_active, s_done;
  logic [15:0] s_addr;
  logic [7:0]  s_dout;

  // Memory models: main returns the low address byte, short one XORs it with A5
  assign bus_in   = addr[7:0];
  assign s_bus_in = s_addr[7:0] ^ 8'hA5;

  cpu_oam_dma_arbiter #(.XFER_LEN(256), .ALIGN_EN(1'b1)) u_dut (
    .CLK(CLK), .RESET_n(RESET_n), .ENABLE(ENABLE),
    .CPU_ADDR(cpu_addr), .CPU_DATA_OUT(cpu_dout), .CPU_RW_n(cpu_rw),
    .BUS_DATA_IN(bus_in), .CPU_RDY(rdy), .ADDR(addr), .DATA_OUT(dout),
    .RW_n(rw), .DMA_ACTIVE(active), .DMA_DONE(done)
  );

  cpu_oam_dma_arbiter #(.XFER_LEN(4), .ALIGN_EN(1'b0)) u_short (
    .CLK(CLK), .RESET_n(RESET_n), .ENABLE(ENABLE),
    .CPU_ADDR(s_cpu_addr), .CPU_DATA_OUT(s_cpu_dout), .CPU_RW_n(s_cpu_rw),
    .BUS_DATA_IN(s_bus_in), .CPU_RDY(s_rdy), .ADDR(s_addr), .DATA_OUT(s_dout),
    .RW_n(s_rw), .DMA_ACTIVE(s_active), .DMA_DONE(s_done)
  );

  // Selected-instance view
  logic        sel;
  logic [15:0] m_addr;
  logic [7:0]  m_dout;
  logic        m_rw, m_rdy, m_active, m_done;
  assign m_addr   = sel ? s_addr   : addr;
  assign m_dout   = sel ? s_dout   : dout;
  assign m_rw     = sel ? s_rw     : rw;
  assign m_rdy    = sel ? s_rdy    : rdy;
  assign m_active = sel ? s_active : active;
  assign m_done   = sel ? s_done   : done;

  int passes = 0;
  int total  = 0;
  bit par    = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RESET_n && ENABLE) par = ~par;
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic r);
    if (sel) begin
      s_cpu_addr = a; s_cpu_dout = d; s_cpu_rw = r;
    end else begin
      cpu_addr = a; cpu_dout = d; cpu_rw = r;
    end
  endtask

  task automatic align_par(input bit p);
    for (int i = 0; i < 2 && par != p; i++) begin
      drive(16'h8000, 8'h00, 1'b1);
      tick();
    end
  endtask

  // Trigger a DMA on the selected instance and follow it cycle by cycle
  task automatic run_dma(input logic [7:0] page, input int len, input int exp_stall,
                         input int exp_dummy, input logic [7:0] key, input bit chk_par,
                         input int gate_at, input int abort_at);
    int  stall = 0, rd = 0, wr = 0, dummy = 0, done_n = 0, bad_act = 0, bad_par = 0;
    bit  fin = 1'b0, gated = 1'b0, frozen;
    logic [27:0] snap;
    drive(16'h4014, page, 1'b0);
    #1;
    chk("trig_addr", m_addr, 16'h4014);
    chk("trig_rw", m_rw, 1'b0);
    chk("trig_data", m_dout, page);
    chk("trig_rdy", m_rdy, 1'b1);
    tick();
    // Stalled CPU keeps presenting a trigger write; it must not reach the bus
    drive(16'h4014, 8'hEE, 1'b0);
    for (int c = 0; c < 700; c++) begin
      #1;
      if (m_done) done_n++;
      if (m_rdy) begin
        if (m_active) bad_act++;
        fin = 1'b1;
        break;
      end
      stall++;
      if (!m_active) bad_act++;
      if (m_rw == 1'b0) begin
        chk("wr_addr", m_addr, 16'h2004);
        chk("wr_data", m_dout, 8'(wr) ^ key);
        wr++;
      end else if (m_addr == 16'h4014) begin
        dummy++;
      end else begin
        chk("rd_addr", m_addr, {page, 8'(rd)});
        if (chk_par && par) bad_par++;
        if (rd == abort_at) begin
          #1 RESET_n = 1'b0;
          par = 1'b0;
          #1;
          chk("abort_rdy", m_rdy, 1'b1);
          chk("abort_active", m_active, 1'b0);
          chk("abort_addr", m_addr, 16'h4014);
          chk("abort_rw", m_rw, 1'b0);
          drive(16'h8000, 8'h00, 1'b1);
          tick();
          #2 RESET_n = 1'b1;
          return;
        end
        rd++;
        if (wr == gate_at && !gated) begin
          gated  = 1'b1;
          frozen = 1'b1;
          snap   = {m_addr, m_dout, m_rw, m_rdy, m_active, m_done};
          ENABLE = 1'b0;
          for (int g = 0; g < 10; g++) begin
            tick();
            #1;
            if ({m_addr, m_dout, m_rw, m_rdy, m_active, m_done} !== snap) frozen = 1'b0;
          end
          chk("gate_frozen", frozen, 1'b1);
          ENABLE = 1'b1;
        end
      end
      tick();
    end
    drive(16'h8000, 8'h00, 1'b1);
    chk("release_seen", fin, 1'b1);
    chk("stall_cycles", stall, exp_stall);
    chk("read_count", rd, len);
    chk("write_count", wr, len);
    chk("dummy_reads", dummy, exp_dummy);
    chk("active_eq_not_rdy", bad_act, 0);
    chk("reads_even", bad_par, 0);
    chk("done_pulses", done_n, 1);
    tick();
    #1;
    chk("done_width", m_done, 1'b0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        r;
    logic [15:0] exp_a;
    logic [7:0]  exp_d;
    logic        exp_r;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h8000, 8'h00, 1'b1, 16'h8000, 8'h00, 1'b1, 1'b1};
    vecs[1] = '{16'h0200, 8'h55, 1'b0, 16'h0200, 8'h55, 1'b0, 1'b1};
    vecs[2] = '{16'h4014, 8'h3C, 1'b1, 16'h4014, 8'h3C, 1'b1, 1'b1};
    vecs[3] = '{16'h4015, 8'hAA, 1'b0, 16'h4015, 8'hAA, 1'b0, 1'b1};
    vecs[4] = '{16'h2004, 8'h81, 1'b0, 16'h2004, 8'h81, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFC, 8'h00, 1'b1, 16'hFFFC, 8'h00, 1'b1, 1'b1};

    sel = 1'b0;
    RESET_n = 1'b0;
    ENABLE  = 1'b1;
    cpu_addr = 16'h1234; cpu_dout = 8'h5A; cpu_rw = 1'b0;
    s_cpu_addr = 16'h8000; s_cpu_dout = 8'h00; s_cpu_rw = 1'b1;
    #2;
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_active", active, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", addr, 16'h1234);
    chk("rst_rw", rw, 1'b0);
    chk("rst_short_rdy", s_rdy, 1'b1);
    cpu_addr = 16'h8000; cpu_dout = 8'h00; cpu_rw = 1'b1;
    #10 RESET_n = 1'b1;
    par = 1'b0;

    // Pass-through table
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a, vecs[i].d, vecs[i].r);
      #1;
      chk("pt_addr", addr, vecs[i].exp_a);
      chk("pt_data", dout, vecs[i].exp_d);
      chk("pt_rw", rw, vecs[i].exp_r);
      chk("pt_rdy", rdy, vecs[i].exp_rdy);
      chk("pt_active", active, 1'b0);
      tick();
    end

    // Even trigger with a 10-clock ENABLE gap mid-transfer
    align_par(1'b0);
    run_dma(8'h02, 256, 513, 1, 8'h00, 1'b1, 100, -1);

    // Odd trigger: one extra alignment cycle
    align_par(1'b1);
    run_dma(8'h02, 256, 514, 2, 8'h00, 1'b1, -1, -1);

    // Short instance: 4 bytes from page 3, no alignment
    sel = 1'b1;
    run_dma(8'h03, 4, 9, 1, 8'hA5, 1'b0, -1, -1);
    sel = 1'b0;

    // Reset during the read of index 0x40
    align_par(1'b0);
    run_dma(8'h02, 256, 0, 0, 8'h00, 1'b1, -1, 8'h40);
    begin
      int dn = 0;
      for (int i = 0; i < 4; i++) begin
        #1;
        if (done) dn++;
        chk("post_abort_rdy", rdy, 1'b1);
        tick();
      end
      chk("post_abort_done", dn, 0);
    end

    // Fresh transfer after abort restarts from index 0
    align_par(1'b0);
    run_dma(8'h02, 256, 513, 1, 8'h00, 1'b1, -1, -1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
